// File: rtl/mem_ctrl.sv
// Byte-serial memory bus controller arbitrating instruction fetch and load/store.
// Reads are pipelined one byte per cycle; I/O stores honour io_buffer_full with a gap cycle.
//
// state  | meaning
// IDLE   | bus quiet, waiting for a request (load/store wins over fetch)
// IF_RD  | issuing/capturing the 4 bytes of an instruction fetch
// LS_RD  | issuing/capturing the 1, 2 or 4 bytes of a load
// LS_WR  | writing the 1, 2 or 4 bytes of a store
module mem_ctrl #(
   parameter int unsigned IO_SEL_HI  = 17,
   parameter logic [1:0]  IO_SEL_VAL = 2'b11
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic [7:0]  mem_din,
   output logic [7:0]  mem_dout,
   output logic [31:0] mem_a,
   output logic        mem_wr,
   input  logic        io_buffer_full,
   input  logic        clr_in,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_done,
   output logic [31:0] if_data,
   input  logic        ls_req,
   input  logic        ls_wr,
   input  logic [1:0]  ls_size,
   input  logic [31:0] ls_addr,
   input  logic [31:0] ls_wdata,
   output logic        ls_done,
   output logic [31:0] ls_rdata
);
   typedef enum logic [1:0] {IDLE, IF_RD, LS_RD, LS_WR} state_t;

   state_t      st;
   logic [31:0] base, wdata, rbuf, rbuf_next;
   logic [1:0]  idx, last, pend_idx;
   logic        issuing, pend, gap, wr_q, rdy_q;
   logic        io_cur, wr_ok, rewind;

   function automatic logic [1:0] last_of(input logic [1:0] size);
      case (size)
         2'd0:    last_of = 2'd0;
         2'd1:    last_of = 2'd1;
         default: last_of = 2'd3;
      endcase
   endfunction

   assign io_cur = (mem_a[IO_SEL_HI -: 2] == IO_SEL_VAL);
   assign wr_ok  = wr_q & ~(io_cur & io_buffer_full);
   assign mem_wr = wr_ok & rdy_in;
   // A byte issued just before a stall was never captured; it must go out again.
   assign rewind = pend & ~rdy_q;

   always_comb begin
      rbuf_next = rbuf;
      rbuf_next[{pend_idx, 3'b000} +: 8] = mem_din;
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         st       <= IDLE;
         base     <= '0;
         wdata    <= '0;
         rbuf     <= '0;
         idx      <= '0;
         last     <= '0;
         pend_idx <= '0;
         issuing  <= 1'b0;
         pend     <= 1'b0;
         gap      <= 1'b0;
         wr_q     <= 1'b0;
         rdy_q    <= 1'b0;
         mem_a    <= '0;
         mem_dout <= '0;
         if_done  <= 1'b0;
         ls_done  <= 1'b0;
         if_data  <= '0;
         ls_rdata <= '0;
      end else begin
         rdy_q   <= rdy_in;
         if_done <= 1'b0;
         ls_done <= 1'b0;
         if (st == IF_RD && clr_in) begin
            st      <= IDLE;
            mem_a   <= '0;
            issuing <= 1'b0;
            pend    <= 1'b0;
         end else if (rdy_in) begin
            case (st)
               IDLE: begin
                  // Requesters still hold req during the done cycle; skip it.
                  if (!if_done && !ls_done) begin
                     if (ls_req) begin
                        base     <= ls_addr;
                        wdata    <= ls_wdata;
                        last     <= last_of(ls_size);
                        idx      <= '0;
                        mem_a    <= ls_addr;
                        rbuf     <= '0;
                        issuing  <= 1'b1;
                        pend     <= 1'b0;
                        gap      <= 1'b0;
                        if (ls_wr) begin
                           st       <= LS_WR;
                           wr_q     <= 1'b1;
                           mem_dout <= ls_wdata[7:0];
                        end else begin
                           st <= LS_RD;
                        end
                     end else if (if_req && !clr_in) begin
                        st      <= IF_RD;
                        base    <= if_addr;
                        last    <= 2'd3;
                        idx     <= '0;
                        mem_a   <= if_addr;
                        rbuf    <= '0;
                        issuing <= 1'b1;
                        pend    <= 1'b0;
                     end
                  end
               end
               IF_RD, LS_RD: begin
                  if (rewind) begin
                     idx     <= pend_idx;
                     mem_a   <= base + {30'd0, pend_idx};
                     issuing <= 1'b1;
                     pend    <= 1'b0;
                  end else begin
                     if (pend) rbuf <= rbuf_next;
                     if (issuing) begin
                        pend     <= 1'b1;
                        pend_idx <= idx;
                        if (idx == last) begin
                           issuing <= 1'b0;
                           mem_a   <= '0;
                        end else begin
                           idx   <= idx + 2'd1;
                           mem_a <= base + {30'd0, idx + 2'd1};
                        end
                     end else begin
                        pend <= 1'b0;
                     end
                     if (pend && pend_idx == last) begin
                        st   <= IDLE;
                        pend <= 1'b0;
                        if (st == IF_RD) begin
                           if_done <= 1'b1;
                           if_data <= rbuf_next;
                        end else begin
                           ls_done  <= 1'b1;
                           ls_rdata <= rbuf_next;
                        end
                     end
                  end
               end
               LS_WR: begin
                  if (gap) begin
                     gap      <= 1'b0;
                     wr_q     <= 1'b1;
                     mem_a    <= base + {30'd0, idx};
                     mem_dout <= wdata[{idx, 3'b000} +: 8];
                  end else if (wr_ok) begin
                     if (idx == last) begin
                        st       <= IDLE;
                        wr_q     <= 1'b0;
                        mem_a    <= '0;
                        mem_dout <= '0;
                        ls_done  <= 1'b1;
                     end else if (io_cur) begin
                        // io_buffer_full lags a cycle, so leave the bus quiet once.
                        gap   <= 1'b1;
                        wr_q  <= 1'b0;
                        mem_a <= '0;
                        idx   <= idx + 2'd1;
                     end else begin
                        idx      <= idx + 2'd1;
                        mem_a    <= base + {30'd0, idx + 2'd1};
                        mem_dout <= wdata[{idx + 2'd1, 3'b000} +: 8];
                     end
                  end
               end
               default: st <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: expected reads/writes queued at request time,
// checked when the controller pulses done or drives a write.
module tb_mem_ctrl;
   logic        clk_in = 1'b0;
   logic        rst_in, rdy_in, io_buffer_full, clr_in;
   logic        if_req, ls_req, ls_wr;
   logic [1:0]  ls_size;
   logic [31:0] if_addr, ls_addr, ls_wdata;
   logic [7:0]  mem_din, mem_dout;
   logic [31:0] mem_a, if_data, ls_rdata;
   logic        mem_wr, if_done, ls_done;

   always #5 clk_in = ~clk_in;

   mem_ctrl #(.IO_SEL_HI(17), .IO_SEL_VAL(2'b11)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
      .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
      .io_buffer_full(io_buffer_full), .clr_in(clr_in),
      .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
      .ls_req(ls_req), .ls_wr(ls_wr), .ls_size(ls_size), .ls_addr(ls_addr),
      .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata)
   );

   // Byte RAM: data one cycle after address; a frozen bus returns junk.
   logic [7:0] ram [0:262143];
   always @(posedge clk_in) mem_din <= rdy_in ? ram[mem_a[17:0]] : 8'hEE;

   int n_cmp = 0;
   int n_bad = 0;
   logic [31:0] if_q [$];
   logic [32:0] ls_q [$];
   logic [39:0] wr_q [$];
   int n, cnt_a, cnt_w;
   bit hit;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic mon();
      logic [32:0] e;
      if (mem_wr) begin
         if (wr_q.size() == 0) chk("wr_unexpected", 64'(wr_q.size()), 64'd1);
         else chk("wr_addr_data", 64'({mem_a, mem_dout}), 64'(wr_q.pop_front()));
      end
      if (if_done) begin
         if (if_q.size() == 0) chk("if_unexpected", 64'(if_q.size()), 64'd1);
         else chk("if_data", 64'(if_data), 64'(if_q.pop_front()));
      end
      if (ls_done) begin
         if (ls_q.size() == 0) chk("ls_unexpected", 64'(ls_q.size()), 64'd1);
         else begin
            e = ls_q.pop_front();
            if (e[32]) chk("ls_rdata", 64'(ls_rdata), 64'(e[31:0]));
            else chk("st_drained", 64'(wr_q.size()), 64'd0);
         end
      end
   endtask

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic probe();
      @(negedge clk_in);
      mon();
   endtask

   task automatic cycle();
      step();
      probe();
   endtask

   task automatic wait_for(input bit on_ls, input int max_cyc, input string tag, output int lat);
      bit got;
      got = 1'b0;
      lat = 0;
      for (int i = 1; i <= max_cyc && !got; i++) begin
         cycle();
         got = on_ls ? ls_done : if_done;
         if (got) lat = i;
      end
      if (!got) chk(tag, 64'(got), 64'd1);
   endtask

   task automatic put32(input int a, input logic [31:0] w);
      for (int i = 0; i < 4; i++) ram[(a + i) & 32'h3FFFF] = w[8*i +: 8];
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 262144; i++) ram[i] = 8'h00;
      put32(32'h100, 32'h00000013);
      put32(32'h110, 32'hEFBEADDE);
      put32(32'h120, 32'h99999999);
      put32(32'h130, 32'h12345678);
      put32(32'h200, 32'hDDCCBBAA);
      put32(32'h300, 32'h44332211);
      put32(32'h3FFFE, 32'hD4C3B2A1);

      rst_in = 1'b1; rdy_in = 1'b1; io_buffer_full = 1'b0; clr_in = 1'b0;
      if_req = 1'b0; ls_req = 1'b0; ls_wr = 1'b0; ls_size = 2'd0;
      if_addr = '0; ls_addr = '0; ls_wdata = '0;
      cycle(); cycle();
      chk("rst_mem_a", 64'(mem_a), 64'd0);
      chk("rst_mem_wr", 64'(mem_wr), 64'd0);
      chk("rst_mem_dout", 64'(mem_dout), 64'd0);
      chk("rst_if_done", 64'(if_done), 64'd0);
      chk("rst_ls_done", 64'(ls_done), 64'd0);
      step(); rst_in = 1'b0; probe();

      // Word fetch with exact cycle timing
      step(); if_req = 1'b1; if_addr = 32'h100; if_q.push_back(32'h00000013); probe();
      for (int k = 1; k <= 4; k++) begin
         cycle();
         chk("fetch_addr", 64'(mem_a), 64'(32'h100 + k - 1));
      end
      cycle(); chk("fetch_early_done", 64'(if_done), 64'd0);
      cycle(); chk("fetch_done_c6", 64'(if_done), 64'd1);
      step(); if_req = 1'b0; probe();
      chk("idle_mem_a", 64'(mem_a), 64'd0);

      // Load beats a simultaneous fetch
      step();
      ls_req = 1'b1; ls_wr = 1'b0; ls_size = 2'd1; ls_addr = 32'h200;
      if_req = 1'b1; if_addr = 32'h300;
      ls_q.push_back({1'b1, 32'h0000BBAA}); if_q.push_back(32'h44332211);
      probe();
      cycle(); chk("ld_addr0", 64'(mem_a), 64'h200);
      cycle(); chk("ld_addr1", 64'(mem_a), 64'h201);
      cycle(); chk("ld_idle_c3", 64'(mem_a), 64'd0);
      cycle(); chk("ld_done_c4", 64'(ls_done), 64'd1);
      step(); ls_req = 1'b0; probe();
      cycle(); chk("fetch_after_ld", 64'(mem_a), 64'h300);
      wait_for(1'b0, 20, "fetch_after_ld_timeout", n);
      step(); if_req = 1'b0; probe();

      // Plain word store
      step();
      ls_req = 1'b1; ls_wr = 1'b1; ls_size = 2'd2; ls_addr = 32'h500; ls_wdata = 32'hCAFEF00D;
      wr_q.push_back({32'h500, 8'h0D}); wr_q.push_back({32'h501, 8'hF0});
      wr_q.push_back({32'h502, 8'hFE}); wr_q.push_back({32'h503, 8'hCA});
      ls_q.push_back({1'b0, 32'h0});
      probe();
      for (int k = 1; k <= 4; k++) begin
         cycle();
         chk("st_wr_active", 64'(mem_wr), 64'd1);
      end
      cycle(); chk("st_done_c5", 64'(ls_done), 64'd1);
      step(); ls_req = 1'b0; ls_wr = 1'b0; probe();

      // Fetch address wraps past 2^32
      step(); if_req = 1'b1; if_addr = 32'hFFFFFFFE; if_q.push_back(32'hD4C3B2A1); probe();
      cycle(); cycle();
      cycle(); chk("wrap_addr2", 64'(mem_a), 64'd0);
      cycle(); chk("wrap_addr3", 64'(mem_a), 64'd1);
      wait_for(1'b0, 10, "wrap_timeout", n);
      step(); if_req = 1'b0; probe();

      // Two-byte I/O store needs a quiet cycle between bytes
      step();
      ls_req = 1'b1; ls_wr = 1'b1; ls_size = 2'd1; ls_addr = 32'h30010; ls_wdata = 32'h00009988;
      wr_q.push_back({32'h30010, 8'h88}); wr_q.push_back({32'h30011, 8'h99});
      ls_q.push_back({1'b0, 32'h0});
      probe();
      cycle(); chk("io_wr_b0", 64'(mem_wr), 64'd1);
      cycle(); chk("io_gap_wr", 64'(mem_wr), 64'd0);
      chk("io_gap_addr", 64'(mem_a), 64'd0);
      cycle(); chk("io_wr_b1", 64'(mem_wr), 64'd1);
      cycle(); chk("io_done", 64'(ls_done), 64'd1);
      step(); ls_req = 1'b0; ls_wr = 1'b0; probe();

      // ls_size 3 behaves as a word
      step();
      ls_req = 1'b1; ls_size = 2'd3; ls_addr = 32'h200;
      ls_q.push_back({1'b1, 32'hDDCCBBAA});
      probe();
      wait_for(1'b1, 20, "ld3_timeout", n);
      chk("ld3_latency", 64'(n), 64'd6);
      step(); ls_req = 1'b0; probe();

      // I/O store blocked while the buffer is full
      step();
      ls_req = 1'b1; ls_wr = 1'b1; ls_size = 2'd0; ls_addr = 32'h30000; ls_wdata = 32'h00000041;
      io_buffer_full = 1'b1;
      wr_q.push_back({32'h30000, 8'h41}); ls_q.push_back({1'b0, 32'h0});
      probe();
      for (int k = 1; k <= 3; k++) begin
         cycle();
         chk("io_full_hold", 64'(mem_wr), 64'd0);
      end
      step(); io_buffer_full = 1'b0; probe();
      chk("io_full_wr", 64'(mem_wr), 64'd1);
      chk("io_full_dout", 64'(mem_dout), 64'h41);
      cycle(); chk("io_full_done", 64'(ls_done), 64'd1);
      step(); ls_req = 1'b0; ls_wr = 1'b0; probe();

      // Bus freeze after byte 1 of a fetch
      step(); if_req = 1'b1; if_addr = 32'h110; if_q.push_back(32'hEFBEADDE); probe();
      cnt_a = 0; cnt_w = 0; hit = 1'b0;
      for (int k = 1; k <= 30 && !hit; k++) begin
         step();
         if (k == 3) rdy_in = 1'b0;
         if (k == 5) rdy_in = 1'b1;
         probe();
         if (rdy_in && mem_a == 32'h111) cnt_a++;
         if (mem_wr) cnt_w++;
         hit = if_done;
      end
      chk("stall_done", 64'(hit), 64'd1);
      chk("stall_reissue", 64'(cnt_a), 64'd2);
      chk("stall_no_wr", 64'(cnt_w), 64'd0);
      step(); if_req = 1'b0; probe();

      // Flush mid-fetch, then a fresh fetch
      step(); if_req = 1'b1; if_addr = 32'h120; probe();
      cycle();
      step(); clr_in = 1'b1; probe();
      step(); clr_in = 1'b0; if_req = 1'b0; probe();
      chk("clr_idle_addr", 64'(mem_a), 64'd0);
      chk("clr_no_done_c3", 64'(if_done), 64'd0);
      cycle(); chk("clr_no_done_c4", 64'(if_done), 64'd0);
      step(); if_req = 1'b1; if_addr = 32'h130; if_q.push_back(32'h12345678); probe();
      wait_for(1'b0, 20, "clr_refetch_timeout", n);
      chk("refetch_latency", 64'(n), 64'd6);
      step(); if_req = 1'b0; probe();

      // Reset aborts a word store in cycle 2
      step();
      ls_req = 1'b1; ls_wr = 1'b1; ls_size = 2'd2; ls_addr = 32'h400; ls_wdata = 32'h44332211;
      wr_q.push_back({32'h400, 8'h11}); wr_q.push_back({32'h401, 8'h22});
      probe();
      cycle(); chk("rst_st_b0", 64'(mem_wr), 64'd1);
      step(); rst_in = 1'b1; probe();
      step(); rst_in = 1'b0; ls_req = 1'b0; ls_wr = 1'b0; probe();
      chk("rst_abort_wr", 64'(mem_wr), 64'd0);
      chk("rst_abort_a", 64'(mem_a), 64'd0);
      chk("rst_abort_dout", 64'(mem_dout), 64'd0);
      chk("rst_abort_ifdata", 64'(if_data), 64'd0);
      chk("rst_abort_lsrdata", 64'(ls_rdata), 64'd0);
      chk("rst_abort_lsdone", 64'(ls_done), 64'd0);
      cycle(); chk("rst_after_wr", 64'(mem_wr), 64'd0);
      cycle();

      chk("if_q_left", 64'(if_q.size()), 64'd0);
      chk("ls_q_left", 64'(ls_q.size()), 64'd0);
      chk("wr_q_left", 64'(wr_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have parameters: IO_SEL_HI, default 17, MSB of the 2-bit I/O select field; IO_SEL_VAL, default 2'b11, field value marking an I/O address.
REQ-002 SHALL have ports, one per line: name, direction, width, meaning.
- clk_in  in  1  system clock; one clock domain; every register on its rising edge.
- rst_in  in  1  synchronous, active-high reset.
- rdy_in  in  1  bus owned by CPU; low = frozen.
- mem_din  in  8  read byte, valid one cycle after its address.
- mem_dout  out  8  write byte.
- mem_a  out  32  byte address.
- mem_wr  out  1  1 = write this cycle.
- io_buffer_full  in  1  I/O output buffer full.
- clr_in  in  1  flush: abort instruction fetch.
- if_req  in  1  fetch request, held until if_done.
- if_addr  in  32  fetch address.
- if_done  out  1  one-cycle pulse, if_data valid.
- if_data  out  32  fetched word, little-endian.
- ls_req  in  1  load/store request, held until ls_done.
- ls_wr  in  1  1 = store.
- ls_size  in  2  0 = byte, 1 = half, 2 = word.
- ls_addr  in  32  load/store address.
- ls_wdata  in  32  store data, low bytes used.
- ls_done  out  1  one-cycle pulse.
- ls_rdata  out  32  load data, zero-extended to 32 bits.

Function
REQ-003 SHALL use states IDLE, IF_RD, LS_RD, LS_WR.
REQ-004 In IDLE, ls_req SHALL win over if_req; the chosen request and its operands SHALL be latched and the state entered on the next edge.
REQ-005 Transfer length N SHALL be 4 for fetch and 1, 2 or 4 for ls_size 0, 1 or 2; ls_size 3 SHALL be treated as 4.
REQ-006 Byte i SHALL be issued on mem_a as base+i, i = 0..N-1, in ascending order, one byte per cycle when not stalled.
REQ-007 Reads SHALL be pipelined: capture mem_din for byte i in the cycle after its issue, into bits [8i+7:8i].
REQ-008 Unstalled read latency: request seen in cycle 0, byte 0 issued in cycle 1, done pulse and data valid in cycle N+2.
REQ-009 Unstalled write latency: bytes issued in cycles 1..N with mem_wr=1 and mem_dout = ls_wdata[8i+7:8i]; ls_done pulses in cycle N+1.
REQ-010 In IDLE and after completion, mem_wr SHALL be 0 and mem_a SHALL be 0.
REQ-011 When rdy_in=0, all state, counters and outputs SHALL hold; mem_wr SHALL be forced to 0.
REQ-012 A read byte in flight when rdy_in fell SHALL be discarded and re-issued after rdy_in returns high; no byte SHALL be captured unless rdy_in was high in both its issue and capture cycles.
REQ-013 I/O address = addr[IO_SEL_HI:IO_SEL_HI-1]==IO_SEL_VAL.
REQ-014 An I/O store byte SHALL NOT be issued while io_buffer_full=1; the byte waits.
REQ-015 Each I/O write SHALL be followed by one mandatory idle bus cycle before the next issue, since io_buffer_full lags one cycle.
REQ-016 I/O reads SHALL follow REQ-007 unchanged.
REQ-017 clr_in=1 during IF_RD SHALL drop the fetch: state returns to IDLE on the next edge, no if_done, in-flight byte ignored.
REQ-018 clr_in SHALL NOT affect LS_RD or LS_WR; stores always complete.
REQ-019 clr_in in IDLE SHALL suppress accepting if_req in that cycle.
REQ-020 The done pulse SHALL last exactly one cycle.
REQ-021 The controller SHALL return to IDLE in the done cycle and accept a new request in the next cycle.
REQ-022 Address increments SHALL wrap modulo 2^32.

Reset
REQ-023 rst_in=1 at any edge SHALL force IDLE and zero if_done, ls_done, mem_wr, mem_a, mem_dout, if_data, ls_rdata and counters, aborting any transfer including a partial store.
REQ-024 Reset SHALL take priority over rdy_in and clr_in.

Verification
REQ-025 Fetch: if_addr=0x100, RAM 0x100..0x103 = 13 00 00 00 -> mem_a 0x100..0x103 in cycles 1-4, if_done in cycle 6, if_data=0x00000013.
REQ-026 Simultaneous ls_req (load, size 1, 0x200 = AA BB) and if_req -> load first; ls_rdata=0x0000BBAA in cycle 4; fetch starts in cycle 5.
REQ-027 Store byte 0x41 to 0x30000 with io_buffer_full=1 for 3 cycles -> mem_wr stays 0 for those cycles, then one write with mem_dout=0x41, then ls_done.
REQ-028 rdy_in low for 2 cycles after byte 1 of a word fetch -> byte 1 re-issued; if_data equals memory contents; mem_wr=0 throughout.
REQ-029 clr_in in cycle 2 of a fetch -> no if_done; IDLE next cycle; a new if_req then completes normally.
REQ-030 rst_in during cycle 2 of a 4-byte store -> no further mem_wr; all outputs 0 on the next cycle.
